vend_sequencer: RTL
===================

// Module: vend_sequencer
// PURPOSE
//  Transaction controller between the keypad front end and the dispense/change
//  mechanisms of the candy vending system. Accumulates coin credit, arbitrates
//  one-cycle key pulses (coin, vend, change) and sequences item dispense and
//  coin-by-coin change return over req/ack handshakes.
//  Exports credit and a per-item can_buy mask to the display logic.
// PARAMETERS
//  CREDIT_W    8   credit register width, units of 100
//  MAX_CREDIT  20  credit ceiling in units; a coin that would exceed it is rejected
//  PRICE0      1   item 0 price, units (PRICE1..PRICE4 likewise)
//  PRICE1      2   item 1 price, units
//  PRICE2      3   item 2 price, units
//  PRICE3      5   item 3 price, units
//  PRICE4      7   item 4 price, units
// PORTS
//  clk         in   1         system clock, rising edge
//  reset       in   1         asynchronous, active-low reset
//  coin_100    in   1         1-cycle pulse, 100 coin inserted
//  coin_500    in   1         1-cycle pulse, 500 coin inserted
//  vend_req    in   1         1-cycle pulse, vend item 'sel'
//  change_req  in   1         1-cycle pulse, return all credit
//  sel         in   3         item index 0..4, sampled with vend_req
//  disp_req    out  1         dispense request, level, held until disp_ack
//  disp_item   out  3         item index, stable while disp_req=1
//  disp_ack    in   1         dispenser done; sampled only while disp_req=1
//  chg_req     out  1         request release of one 100 coin
//  chg_ack     in   1         one coin released; sampled only while chg_req=1
//  credit      out  CREDIT_W  current credit, units
//  can_buy     out  5         bit i = IDLE && credit >= PRICEi
//  busy        out  1         1 in DISPENSE or CHANGE
//  coin_reject out  1         1-cycle pulse, coin not accepted (return chute)
//  vend_err    out  1         1-cycle pulse, vend refused
// BEHAVIOUR
//  Reset (any time, incl. mid-transaction): state=IDLE, credit=0, all outputs 0;
//   pending handshake abandoned, credit discarded.
//  FSM: IDLE, DISPENSE, CHANGE. All outputs registered except can_buy
//   (combinational from credit and state).
//  IDLE, per-cycle priority: change_req > vend_req > coins.
//   change_req: credit>0 -> CHANGE next cycle; credit=0 -> ignored.
//   vend_req: sel<=4 && credit>=PRICEsel -> latch disp_item=sel, disp_req=1,
//    enter DISPENSE next cycle. Otherwise vend_err pulses next cycle, stay IDLE.
//   Coins: sum = 1*coin_100 + 5*coin_500 (both may pulse together).
//    credit+sum<=MAX_CREDIT -> credit+=sum next cycle.
//    Otherwise all coins that cycle are rejected: coin_reject=1 for one cycle.
//   Coins in the same cycle as an accepted vend/change are rejected.
//  DISPENSE: disp_req=1, disp_item stable. On disp_ack=1 at a clock edge:
//   credit-=PRICEsel, disp_req=0, -> IDLE. Latency req->IDLE = ack cycle+1.
//  CHANGE: chg_req=1 while credit>0. Each edge with chg_ack=1 decrements
//   credit by 1. Back-to-back acks are legal (one coin per cycle).
//   When decrement makes credit 0: chg_req=0 same edge, -> IDLE.
//  Outside IDLE: coin pulses -> coin_reject; vend_req/change_req ignored
//   (no vend_err). ack inputs outside their req window are ignored.
//  Arithmetic: credit never wraps. MAX_CREDIT+5 must fit CREDIT_W
//   (elaboration check). Price compare is unsigned.
//  sel 5..7: always vend_err.
// TESTING
//  1 reset low mid-DISPENSE with credit=7 -> credit=0, disp_req=0, state IDLE
//    immediately (async).
//  2 coin_500, coin_100, coin_100 -> credit=7; can_buy=5'b11111;
//    no coin_reject pulses.
//  3 credit=7, vend sel=3 -> disp_req=1, disp_item=3; ack after 4 cycles
//    -> credit=2, can_buy=5'b00011, busy=0.
//  4 credit=2, vend sel=4 -> vend_err 1-cycle pulse, credit=2;
//    vend sel=6 -> vend_err.
//  5 credit=18, coin_500 -> coin_reject, credit stays 18;
//    coin_100 and coin_500 in the same cycle at credit 14 -> credit=20.
//  6 credit=3, change_req, chg_ack on 3 consecutive cycles -> credit 2,1,0;
//    chg_req low after 3rd ack; coin_100 during CHANGE -> coin_reject.

Source files
------------

// File: rtl/vend_sequencer.sv
// Vending transaction controller: coin credit, vend/change arbitration,
// and req/ack sequencing of the dispenser and the change hopper.
module vend_sequencer #(
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 20,
    parameter int PRICE0     = 1,
    parameter int PRICE1     = 2,
    parameter int PRICE2     = 3,
    parameter int PRICE3     = 5,
    parameter int PRICE4     = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_100,
    input  logic                coin_500,
    input  logic                vend_req,
    input  logic                change_req,
    input  logic [2:0]          sel,
    output logic                disp_req,
    output logic [2:0]          disp_item,
    input  logic                disp_ack,
    output logic                chg_req,
    input  logic                chg_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic [4:0]          can_buy,
    output logic                busy,
    output logic                coin_reject,
    output logic                vend_err
);

    localparam int CW1 = CREDIT_W + 1;

    generate
        if (MAX_CREDIT + 5 > (1 << CREDIT_W) - 1) begin : g_width_chk
            $error("vend_sequencer: MAX_CREDIT+5 does not fit CREDIT_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPENSE = 2'd1,
        S_CHANGE   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic                  disp_req_q, disp_req_d;
    logic [2:0]            disp_item_q, disp_item_d;
    logic                  chg_req_q, chg_req_d;
    logic                  busy_q, busy_d;
    logic                  coin_reject_q, coin_reject_d;
    logic                  vend_err_q, vend_err_d;

    logic                  have_coin;
    logic [CW1-1:0]        coin_sum;
    logic [CW1-1:0]        coin_total;
    logic                  coin_fits;
    logic                  vend_ok;

    function automatic logic [CREDIT_W-1:0] price_of(input logic [2:0] idx);
        logic [CREDIT_W-1:0] p;
        case (idx)
            3'd0:    p = CREDIT_W'(PRICE0);
            3'd1:    p = CREDIT_W'(PRICE1);
            3'd2:    p = CREDIT_W'(PRICE2);
            3'd3:    p = CREDIT_W'(PRICE3);
            3'd4:    p = CREDIT_W'(PRICE4);
            default: p = '0;
        endcase
        return p;
    endfunction

    // One extra bit so the coin sum can never wrap before the ceiling test.
    assign have_coin  = coin_100 | coin_500;
    assign coin_sum   = CW1'(coin_100) + (coin_500 ? CW1'(5) : CW1'(0));
    assign coin_total = {1'b0, credit_q} + coin_sum;
    assign coin_fits  = coin_total <= CW1'(MAX_CREDIT);
    assign vend_ok    = (sel <= 3'd4) && (credit_q >= price_of(sel));

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        disp_req_d    = disp_req_q;
        disp_item_d   = disp_item_q;
        chg_req_d     = chg_req_q;
        coin_reject_d = 1'b0;
        vend_err_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (change_req && credit_q != '0) begin
                    state_d       = S_CHANGE;
                    chg_req_d     = 1'b1;
                    coin_reject_d = have_coin;
                end else if (vend_req && vend_ok) begin
                    state_d       = S_DISPENSE;
                    disp_req_d    = 1'b1;
                    disp_item_d   = sel;
                    coin_reject_d = have_coin;
                end else begin
                    vend_err_d = vend_req;
                    if (have_coin) begin
                        if (coin_fits) begin
                            credit_d = coin_total[CREDIT_W-1:0];
                        end else begin
                            coin_reject_d = 1'b1;
                        end
                    end
                end
            end
            S_DISPENSE: begin
                coin_reject_d = have_coin;
                if (disp_ack) begin
                    credit_d   = credit_q - price_of(disp_item_q);
                    disp_req_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            S_CHANGE: begin
                coin_reject_d = have_coin;
                if (chg_ack && credit_q != '0) begin
                    credit_d = credit_q - CREDIT_W'(1);
                    if (credit_q == CREDIT_W'(1)) begin
                        chg_req_d = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                disp_req_d = 1'b0;
                chg_req_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            disp_req_q    <= 1'b0;
            disp_item_q   <= '0;
            chg_req_q     <= 1'b0;
            busy_q        <= 1'b0;
            coin_reject_q <= 1'b0;
            vend_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            disp_req_q    <= disp_req_d;
            disp_item_q   <= disp_item_d;
            chg_req_q     <= chg_req_d;
            busy_q        <= busy_d;
            coin_reject_q <= coin_reject_d;
            vend_err_q    <= vend_err_d;
        end
    end

    always_comb begin
        can_buy = '0;
        for (int i = 0; i < 5; i++) begin
            can_buy[i] = (state_q == S_IDLE) &&
                         (credit_q >= price_of(3'(i)));
        end
    end

    assign credit      = credit_q;
    assign disp_req    = disp_req_q;
    assign disp_item   = disp_item_q;
    assign chg_req     = chg_req_q;
    assign busy        = busy_q;
    assign coin_reject = coin_reject_q;
    assign vend_err    = vend_err_q;

endmodule
